// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: turns sprite/swap requests into display command words; define SPRITE_CMD_ATTR_EN to add the ATTR word
module sprite_cmd_encoder #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_swap,
  input  logic [5:0]  req_component,
  input  logic [4:0]  req_child,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  req_attr,
  input  logic        frame_flip,
  output logic [31:0] writedata,
  output logic        write,
  output logic        busy,
  output logic        back_buf
);
  typedef enum logic [2:0] {IDLE, VIS, XPOS, YPOS, ATTR, SWAP, GAP} state_t;
  state_t state_q, state_d, ret_q, ret_d, nxt;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] comp_q, comp_d;
  logic [4:0] child_q, child_d;
  logic vis_q, vis_d, hflip_q, hflip_d;
  logic [9:0] x_q, x_d, y_q, y_d, attr_v;
  logic flip_pending_q, flip_pending_d, back_buf_q, back_buf_d;
  logic accept, apply;
  logic [2:0] atype;
  logic [12:0] data;
`ifdef SPRITE_CMD_ATTR_EN
  logic [9:0] attr_q, attr_d;
  assign attr_v = attr_q;
`else
  logic unused_attr;
  assign unused_attr = ^req_attr;
  assign attr_v = '0;
`endif
  assign req_ready = state_q == IDLE && !flip_pending_q && !frame_flip;
  assign accept = req_valid && req_ready;
  assign apply = state_q == IDLE && flip_pending_q;
  assign write = state_q inside {VIS, XPOS, YPOS, ATTR, SWAP};
  assign busy = state_q != IDLE;
  assign back_buf = back_buf_q;
  // request capture, buffer-flip bookkeeping and word packing
  always_comb begin
    comp_d = accept ? req_component : comp_q;
    child_d = accept ? req_child : child_q;
    vis_d = accept ? req_visible : vis_q;
    hflip_d = accept ? req_flip : hflip_q;
    x_d = accept ? req_x : x_q;
    y_d = accept ? req_y : y_q;
`ifdef SPRITE_CMD_ATTR_EN
    attr_d = accept ? req_attr : attr_q;
`endif
    flip_pending_d = !apply && (flip_pending_q || frame_flip);
    back_buf_d = back_buf_q ^ apply;
    atype = state_q == VIS ? 3'd1 : state_q == XPOS ? 3'd2 : state_q == YPOS ? 3'd3 :
            state_q == ATTR ? 3'd4 : 3'd0;
    data = state_q == VIS ? {vis_q, hflip_q, 11'd0} : state_q == XPOS ? {3'd0, x_q} :
           state_q == YPOS ? {3'd0, y_q} : state_q == ATTR ? {3'd0, attr_v} : 13'd0;
    writedata = write ? {comp_q, child_q, state_q == SWAP ? 4'hF : 4'h1, atype, back_buf_q, data} : 32'd0;
  end
  // sequencer: each word state emits one word, then goes to the next word via optional GAP
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    cnt_d = cnt_q;
    nxt = IDLE;
    case (state_q)
      IDLE: if (accept && req_component != 6'd0) state_d = req_swap ? SWAP : VIS;
      VIS: nxt = XPOS;
      XPOS: nxt = YPOS;
`ifdef SPRITE_CMD_ATTR_EN
      YPOS: nxt = ATTR;
`endif
      GAP: begin
        state_d = cnt_q == 4'd0 ? ret_q : GAP;
        cnt_d = cnt_q - 4'd1;
      end
      default: ;
    endcase
    if (write) begin
      state_d = (nxt == IDLE || GAP_CYCLES == 0) ? nxt : GAP;
      ret_d = nxt;
      cnt_d = 4'(GAP_CYCLES - 1);
    end
  end
  // state and captured-field registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      cnt_q <= '0;
      comp_q <= '0;
      child_q <= '0;
      vis_q <= 1'b0;
      hflip_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
`ifdef SPRITE_CMD_ATTR_EN
      attr_q <= '0;
`endif
      flip_pending_q <= 1'b0;
      back_buf_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      comp_q <= comp_d;
      child_q <= child_d;
      vis_q <= vis_d;
      hflip_q <= hflip_d;
      x_q <= x_d;
      y_q <= y_d;
`ifdef SPRITE_CMD_ATTR_EN
      attr_q <= attr_d;
`endif
      flip_pending_q <= flip_pending_d;
      back_buf_q <= back_buf_d;
    end
  end
endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// tb_sprite_cmd_encoder: randomized check of two encoders (GAP_CYCLES 0 and 2) against a word-list model
module tb_sprite_cmd_encoder;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_swap = 1'b0, req_visible = 1'b0, req_flip = 1'b0, frame_flip = 1'b0;
  logic [5:0] req_component = '0;
  logic [4:0] req_child = '0;
  logic [9:0] req_x = '0, req_y = '0, req_attr = '0;
  logic rdy[2], wr[2], bsy[2], bbo[2];
  logic [31:0] wd[2];
  int cmp = 0, err = 0;
  logic model_bb = 1'b1;
`ifdef SPRITE_CMD_ATTR_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  always #5 clk = ~clk;

  sprite_cmd_encoder #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]), .req_swap(req_swap),
    .req_component(req_component), .req_child(req_child), .req_visible(req_visible), .req_flip(req_flip),
    .req_x(req_x), .req_y(req_y), .req_attr(req_attr), .frame_flip(frame_flip),
    .writedata(wd[0]), .write(wr[0]), .busy(bsy[0]), .back_buf(bbo[0]));
  sprite_cmd_encoder #(.GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]), .req_swap(req_swap),
    .req_component(req_component), .req_child(req_child), .req_visible(req_visible), .req_flip(req_flip),
    .req_x(req_x), .req_y(req_y), .req_attr(req_attr), .frame_flip(frame_flip),
    .writedata(wd[1]), .write(wr[1]), .busy(bsy[1]), .back_buf(bbo[1]));

  function automatic logic [31:0] pack(longint c, longint ch, longint act, longint at, longint b, longint dat);
    return 32'(c * 64'd67108864 + ch * 64'd2097152 + act * 64'd131072 + at * 64'd16384 + b * 64'd8192 + dat);
  endfunction

  task automatic scramble();
    req_swap = 1'($urandom); req_component = 6'($urandom); req_child = 5'($urandom);
    req_visible = 1'($urandom); req_flip = 1'($urandom);
    req_x = 10'($urandom); req_y = 10'($urandom); req_attr = 10'($urandom);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp++; if (wr[d] !== 1'b0 || wd[d] !== 32'd0 || bsy[d] !== 1'b0 || bbo[d] !== 1'b1) begin
        err++; $display("FAIL reset_state dut%0d: write=%b data=%h busy=%b back_buf=%b, need 0/0/0/1", d, wr[d], wd[d], bsy[d], bbo[d]);
      end
    end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp++; if (rdy[d] !== 1'b1 || bbo[d] !== 1'b1) begin
        err++; $display("FAIL reset_release dut%0d: ready=%b back_buf=%b, need 1/1", d, rdy[d], bbo[d]);
      end
    end
    model_bb = 1'b1;
  endtask

  task automatic run_req(input bit sw, input logic [5:0] c, input logic [4:0] ch, input bit v, input bit f,
                         input logic [9:0] x, input logic [9:0] y, input logic [9:0] a, input bit fl);
    logic [31:0] w[4];
    int n, g, len, k, wait_n;
    logic bb;
    bb = model_bb;
    n = c == 0 ? 0 : sw ? 1 : NW;
    w[0] = sw ? pack(c, ch, 15, 0, bb, 0) : pack(c, ch, 1, 1, bb, v * 4096 + f * 2048);
    w[1] = pack(c, ch, 1, 2, bb, x);
    w[2] = pack(c, ch, 1, 3, bb, y);
    w[3] = pack(c, ch, 1, 4, bb, a);
    fl = fl && n > 1;
    wait_n = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1]) && wait_n < 50) begin @(negedge clk); wait_n++; end
    cmp++; if (wait_n >= 50) begin err++; $display("FAIL ready_timeout: ready=%b%b, need 11", rdy[0], rdy[1]); end
    req_valid = 1'b1; req_swap = sw; req_component = c; req_child = ch;
    req_visible = v; req_flip = f; req_x = x; req_y = y; req_attr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    for (k = 0; k <= n + (n > 0 ? (n - 1) * 2 : 0) + 1; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic ew, er, eb;
        logic [31:0] ed;
        g = d * 2;
        len = n == 0 ? 0 : n + (n - 1) * g;
        ew = k < len && k % (g + 1) == 0;
        ed = ew ? w[k / (g + 1)] : 32'd0;
        er = k >= len && !(fl && k == len);
        eb = bb ^ (fl && k > len);
        cmp++; if (wr[d] !== ew || wd[d] !== ed || bsy[d] !== (k < len) || rdy[d] !== er || bbo[d] !== eb) begin
          err++; $display("FAIL seq dut%0d k=%0d: write=%b data=%h busy=%b ready=%b bb=%b, need %b %h %b %b %b",
                          d, k, wr[d], wd[d], bsy[d], rdy[d], bbo[d], ew, ed, k < len, er, eb);
        end
      end
      frame_flip = fl && k == 1;
    end
    frame_flip = 1'b0;
    if (fl) model_bb = ~bb;
  endtask

  task automatic test_directed();
    run_req(0, 6'h09, 0, 1, 0, 10'd100, 10'd200, 10'd5, 0);
    cmp++; if (32'h2402E0C8 !== pack(9, 0, 1, 3, 1, 200)) begin err++; $display("FAIL model_ypos: %h, need 2402e0c8", pack(9, 0, 1, 3, 1, 200)); end
    run_req(1, 6'h09, 0, 0, 0, 0, 0, 0, 0);
    run_req(0, 6'h09, 0, 1, 0, 10'd100, 10'd200, 10'd5, 1);
    run_req(0, 6'h00, 5'd3, 1, 1, 10'd1, 10'd2, 10'd3, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      run_req($urandom_range(0, 3) == 0, c, 5'($urandom), 1'($urandom), 1'($urandom),
              10'($urandom), 10'($urandom), 10'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_idle_flip();
    logic bb;
    @(negedge clk);
    bb = model_bb;
    frame_flip = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp++; if (rdy[d] !== 1'b0) begin err++; $display("FAIL flip_comb dut%0d: ready=%b, need 0", d, rdy[d]); end
    end
    @(negedge clk); frame_flip = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cmp++; if (rdy[d] !== 1'b0 || bbo[d] !== bb) begin err++; $display("FAIL flip_apply dut%0d: ready=%b bb=%b, need 0 %b", d, rdy[d], bbo[d], bb); end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp++; if (rdy[d] !== 1'b1 || bbo[d] !== ~bb) begin err++; $display("FAIL flip_done dut%0d: ready=%b bb=%b, need 1 %b", d, rdy[d], bbo[d], ~bb); end
    end
    bb = ~bb;
    frame_flip = 1'b1;
    @(negedge clk);
    @(negedge clk); frame_flip = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cmp++; if (rdy[d] !== 1'b1 || bbo[d] !== ~bb) begin err++; $display("FAIL flip_absorb dut%0d: ready=%b bb=%b, need 1 %b", d, rdy[d], bbo[d], ~bb); end
    end
    model_bb = ~bb;
  endtask

  task automatic test_reset_mid();
    if (model_bb) begin
      @(negedge clk); frame_flip = 1'b1; @(negedge clk); frame_flip = 1'b0; @(negedge clk); @(negedge clk);
      model_bb = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_swap = 1'b0; req_component = 6'h21; req_visible = 1'b1; req_y = 10'd77;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    cmp++; if (wr[0] !== 1'b1 || wd[0] !== pack(33, req_child, 1, 3, 0, 77)) begin
      err++; $display("FAIL mid_ypos: write=%b data=%h, need 1 %h", wr[0], wd[0], pack(33, req_child, 1, 3, 0, 77));
    end
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp++; if (wr[d] !== 1'b0 || wd[d] !== 32'd0 || bbo[d] !== 1'b1 || bsy[d] !== 1'b0) begin
        err++; $display("FAIL mid_reset dut%0d: write=%b data=%h bb=%b busy=%b, need 0 0 1 0", d, wr[d], wd[d], bbo[d], bsy[d]);
      end
    end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cmp++; if (wr[d] !== 1'b0 || wd[d] !== 32'd0 || rdy[d] !== 1'b1) begin
          err++; $display("FAIL post_reset dut%0d k=%0d: write=%b data=%h ready=%b, need 0 0 1", d, k, wr[d], wd[d], rdy[d]);
        end
      end
    end
    model_bb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_idle_flip();
    test_random();
    test_reset_mid();
    run_req(1, 6'h3F, 5'h1F, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
